// File: rtl/inv_filter_bank_if.sv
// Channel bus for inv_filter_bank: raw inputs and polarity in, filtered levels and change pulses out.
interface inv_filter_bank_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] pol;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] chg;

    modport master (output a, output pol, input y, input chg);
    modport slave  (input a, input pol, output y, output chg);
endinterface

// File: rtl/inv_filter_bank.sv
// Bank of glitch-filtered inverters with per-channel polarity and change pulses.
// Define INVF_SYNC_EN to put a 2-flop synchroniser in front of each channel's filter.
module inv_filter_lane #(
    parameter int FILTER = 4,
    parameter int CW     = $clog2(FILTER) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic pol,
    output logic y,
    output logic chg
);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

    logic          x;
    logic          s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          chg_q, chg_d;

`ifdef INVF_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= a;
            sync2_q <= sync1_q;
        end
    end

    assign x = sync2_q;
`else
    assign x = a;
`endif

    // A level is accepted once it has differed from s for FILTER consecutive samples.
    always_comb begin
        s_d   = s_q;
        cnt_d = cnt_q;
        chg_d = 1'b0;
        if (x == s_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            s_d   = x;
            cnt_d = '0;
            chg_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 1'b0;
            cnt_q <= '0;
            chg_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
        end
    end

    assign y   = s_q ^ pol;
    assign chg = chg_q;
endmodule

module inv_filter_bank #(
    parameter int WIDTH  = 8,
    parameter int FILTER = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    inv_filter_bank_if.slave   bus
);
    logic [WIDTH-1:0] y_w;
    logic [WIDTH-1:0] chg_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        inv_filter_lane #(.FILTER(FILTER)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .a     (bus.a[i]),
            .pol   (bus.pol[i]),
            .y     (y_w[i]),
            .chg   (chg_w[i])
        );
    end

    assign bus.y   = y_w;
    assign bus.chg = chg_w;
endmodule
